// File: rtl/clint_ctrl_pkg.sv
// clint_ctrl_pkg: CSR addresses, instruction encodings, cause codes and FSM states
package clint_ctrl_pkg;
  localparam logic [31:0] CSR_MSTATUS = 32'h300;
  localparam logic [31:0] CSR_MTVEC = 32'h305;
  localparam logic [31:0] CSR_MEPC = 32'h341;
  localparam logic [31:0] CSR_MCAUSE = 32'h342;
  localparam logic [31:0] INST_ECALL = 32'h00000073;
  localparam logic [31:0] INST_EBREAK = 32'h00100073;
  localparam logic [31:0] INST_MRET = 32'h30200073;
  localparam logic [31:0] CAUSE_ECALL = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_TIMER = 32'h80000007;
  localparam logic [31:0] CAUSE_EXT = 32'h8000000B;
  localparam logic [5:0] S_IDLE = 6'b000001;
  localparam logic [5:0] S_MEPC = 6'b000010;
  localparam logic [5:0] S_MSTAT = 6'b000100;
  localparam logic [5:0] S_MCAUSE = 6'b001000;
  localparam logic [5:0] S_JUMP = 6'b010000;
  localparam logic [5:0] S_MRET = 6'b100000;
endpackage

// File: rtl/clint_ctrl.sv
// clint_ctrl: trap/interrupt/mret sequencer driving CSR writes, stall and PC redirect
module clint_ctrl
  import clint_ctrl_pkg::*;
#(
  parameter int INT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inst_valid_i,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      inst_addr_i,
  input  logic             jump_flag_i,
  input  logic [31:0]      jump_addr_i,
  input  logic [INT_W-1:0] int_flag_i,
  input  logic [31:0]      csr_mtvec_i,
  input  logic [31:0]      csr_mepc_i,
  input  logic [31:0]      csr_mstatus_i,
  output logic             clint_wr_en_o,
  output logic [31:0]      clint_wr_addr_o,
  output logic [31:0]      clint_wr_data_o,
  output logic             stall_o,
  output logic             int_assert_o,
  output logic [31:0]      int_addr_o
);
  logic [5:0] state;
  logic [31:0] mcause;
  logic is_ecall, is_ebreak, sync_req, async_req, mret_req, idle;
  logic [31:0] mepc_val, cause_val, mstat_trap, mstat_mret;

  // request decode, priority sync > async > mret, and the stall that freezes the pipe
  always_comb begin
    idle = state == S_IDLE;
    is_ecall = inst_valid_i && inst_i == INST_ECALL;
    is_ebreak = inst_valid_i && inst_i == INST_EBREAK;
    sync_req = is_ecall || is_ebreak;
    async_req = |int_flag_i && csr_mstatus_i[3];
    mret_req = inst_valid_i && inst_i == INST_MRET;
    stall_o = !idle || sync_req || async_req || mret_req;
    mepc_val = (!sync_req && jump_flag_i) ? jump_addr_i : inst_addr_i;
    cause_val = is_ecall ? CAUSE_ECALL : is_ebreak ? CAUSE_EBREAK :
                int_flag_i[0] ? CAUSE_TIMER : CAUSE_EXT;
    mstat_trap = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4], 1'b0, csr_mstatus_i[2:0]};
    mstat_mret = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4], csr_mstatus_i[7], csr_mstatus_i[2:0]};
  end

  // FSM with registered outputs: each transition issues the output of the state entered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      mcause <= '0;
      clint_wr_en_o <= 1'b0;
      clint_wr_addr_o <= '0;
      clint_wr_data_o <= '0;
      int_assert_o <= 1'b0;
      int_addr_o <= '0;
    end else begin
      clint_wr_en_o <= 1'b0;
      clint_wr_addr_o <= '0;
      clint_wr_data_o <= '0;
      int_assert_o <= 1'b0;
      int_addr_o <= '0;
      case (state)
        S_IDLE: begin
          if (sync_req || async_req) begin
            state <= S_MEPC;
            mcause <= cause_val;
            clint_wr_en_o <= 1'b1;
            clint_wr_addr_o <= CSR_MEPC;
            clint_wr_data_o <= mepc_val;
          end else if (mret_req) begin
            state <= S_MRET;
            clint_wr_en_o <= 1'b1;
            clint_wr_addr_o <= CSR_MSTATUS;
            clint_wr_data_o <= mstat_mret;
          end
        end
        S_MEPC: begin
          state <= S_MSTAT;
          clint_wr_en_o <= 1'b1;
          clint_wr_addr_o <= CSR_MSTATUS;
          clint_wr_data_o <= mstat_trap;
        end
        S_MSTAT: begin
          state <= S_MCAUSE;
          clint_wr_en_o <= 1'b1;
          clint_wr_addr_o <= CSR_MCAUSE;
          clint_wr_data_o <= mcause;
        end
        S_MCAUSE: begin
          state <= S_JUMP;
          int_assert_o <= 1'b1;
          int_addr_o <= csr_mtvec_i;
        end
        S_MRET: begin
          state <= S_JUMP;
          int_assert_o <= 1'b1;
          int_addr_o <= csr_mepc_i;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
